// File: rtl/mos_la_loader.sv
// mos_la_loader: assembles a 66-bit frame from logic-analyzer bus writes and hands it to a downstream encoder.
module mos_la_loader (
`ifdef USE_POWER_PINS
  inout  wire         vdd,
  inout  wire         vss,
`endif
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] la_data_i,
  input  logic [1:0]  la_sel_i,
  input  logic        la_wr_i,
  output logic [65:0] frame_o,
  output logic        frame_valid_o,
  input  logic        frame_ready_i,
  output logic [31:0] status_o
);
  typedef enum logic {FILL, HOLD} state_t;
  state_t state_q, state_d;
  logic q1_q, q2_q, q3_q, wr_ev, hs;
  logic [31:0] w0_q, w0_d, w1_q, w1_d;
  logic [1:0] mask_q, mask_d;
  logic [65:0] frame_q, frame_d;
  logic err_q, err_d;
  logic [7:0] ovr_q, ovr_d;
  logic [15:0] cnt_q, cnt_d;
  assign wr_ev = q2_q & ~q3_q;
  assign hs = (state_q == HOLD) & frame_ready_i;
  // A write landing in a HOLD cycle is an overrun even if the handshake completes on the same edge.
  always_comb begin
    state_d = state_q;
    w0_d = w0_q;
    w1_d = w1_q;
    mask_d = mask_q;
    frame_d = frame_q;
    err_d = err_q;
    ovr_d = ovr_q;
    cnt_d = cnt_q;
    if (hs) begin
      state_d = FILL;
      cnt_d = cnt_q + 16'd1;
    end
    if (wr_ev) begin
      if (la_sel_i == 2'b11) begin
        mask_d = la_data_i[0] ? 2'b00 : mask_q;
        err_d = la_data_i[0] ? 1'b0 : err_q;
        ovr_d = la_data_i[1] ? 8'd0 : ovr_q;
        cnt_d = la_data_i[2] ? 16'd0 : cnt_d;
      end else if (state_q == HOLD) begin
        ovr_d = (ovr_q == 8'hFF) ? ovr_q : ovr_q + 8'd1;
      end else if (la_sel_i == 2'b00) begin
        w0_d = la_data_i;
        mask_d = mask_q | 2'b01;
      end else if (la_sel_i == 2'b01) begin
        w1_d = la_data_i;
        mask_d = mask_q | 2'b10;
      end else begin
        frame_d = (mask_q == 2'b11) ? {la_data_i[1:0], w1_q, w0_q} : frame_q;
        state_d = (mask_q == 2'b11) ? HOLD : FILL;
        err_d = (mask_q == 2'b11) ? err_q : 1'b1;
        mask_d = 2'b00;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q1_q <= 1'b0;
      q2_q <= 1'b0;
      q3_q <= 1'b0;
      state_q <= FILL;
      w0_q <= '0;
      w1_q <= '0;
      mask_q <= '0;
      frame_q <= '0;
      err_q <= 1'b0;
      ovr_q <= '0;
      cnt_q <= '0;
    end else begin
      q1_q <= la_wr_i;
      q2_q <= q1_q;
      q3_q <= q2_q;
      state_q <= state_d;
      w0_q <= w0_d;
      w1_q <= w1_d;
      mask_q <= mask_d;
      frame_q <= frame_d;
      err_q <= err_d;
      ovr_q <= ovr_d;
      cnt_q <= cnt_d;
    end
  end
  assign frame_o = frame_q;
  assign frame_valid_o = (state_q == HOLD);
  assign status_o = {cnt_q, ovr_q, 4'b0000, err_q, frame_valid_o, mask_q};
endmodule
